// File: rtl/conv_encoder_pkg.sv
// Shared constants and state type for the convolutional encoder scheduler.
// Optional border clear: CONV_ENCODER_SCHED_PAD_CLEAR_EN adds the CLEAR state.
package conv_encoder_pkg;
  localparam int ROWS        = 180;
  localparam int COLS        = 64;
  localparam int PAD         = 3;
  localparam int NUM_FILTERS = 16;

  localparam int W          = COLS + 2*PAD;
  localparam int H          = ROWS + 2*PAD;
  localparam int FIRST_ADDR = PAD*W + PAD;
  localparam int LAST_ADDR  = (PAD+ROWS-1)*W + PAD + COLS - 1;

  localparam int AW = 14;  // address width (input and padded output frame)
  localparam int CW = 7;   // column counter width, holds 0..W-1
  localparam int RW = 8;   // row counter width, holds 0..H-1

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_STREAM,
    S_DRAIN,
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
    S_CLEAR,
`endif
    S_NEXT,
    S_DONE
  } state_t;
endpackage

// File: rtl/conv_encoder_out_addr_gen.sv
// Padded output-frame address generator: steps through active pixels,
// skipping the side borders with a mod-W column counter (no divider).
// With CONV_ENCODER_SCHED_PAD_CLEAR_EN it also sweeps the whole frame
// linearly and flags border addresses for the zero-clear pass.
import conv_encoder_pkg::*;

module conv_encoder_out_addr_gen #(
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
  parameter int ROWS = conv_encoder_pkg::ROWS,
`endif
  parameter int COLS = conv_encoder_pkg::COLS,
  parameter int PAD  = conv_encoder_pkg::PAD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_first,
  input  logic          step_active,
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
  input  logic          load_zero,
  input  logic          step_linear,
  output logic          border,
  output logic          at_end,
`endif
  output logic [AW-1:0] addr
);
  localparam int            FRM_W     = COLS + 2*PAD;
  localparam logic [AW-1:0] A_FIRST   = AW'(PAD*FRM_W + PAD);
  localparam logic [AW-1:0] A_SKIP    = AW'(2*PAD + 1);
  localparam logic [CW-1:0] C_PAD     = CW'(PAD);
  localparam logic [CW-1:0] C_RUN_END = CW'(PAD + COLS - 2);

  logic [CW-1:0] col;

`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
  localparam int            FRM_H  = ROWS + 2*PAD;
  localparam logic [AW-1:0] A_END  = AW'(FRM_W*FRM_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(FRM_W - 1);
  localparam logic [CW-1:0] C_BR   = CW'(PAD + COLS);
  localparam logic [RW-1:0] R_PAD  = RW'(PAD);
  localparam logic [RW-1:0] R_BR   = RW'(PAD + ROWS);

  logic [RW-1:0] row;

  assign border = (row < R_PAD) || (row >= R_BR) || (col < C_PAD) || (col >= C_BR);
  assign at_end = (addr == A_END);
`endif

  // Address / column (/ row) counters; reload wins over stepping.
  always_ff @(posedge clk) begin
    if (rst || load_first) begin
      addr <= A_FIRST;
      col  <= C_PAD;
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
      row  <= R_PAD;
`endif
    end
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
    else if (load_zero) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (step_linear) begin
      addr <= addr + 1'b1;
      if (col == C_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
`endif
    else if (step_active) begin
      if (col >= C_PAD && col <= C_RUN_END) begin
        addr <= addr + 1'b1;
        col  <= col + 1'b1;
      end else begin
        // last active column: jump over right border and next left border
        addr <= addr + A_SKIP;
        col  <= C_PAD;
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
        row  <= row + 1'b1;
`endif
      end
    end
  end
endmodule

// File: rtl/conv_encoder_scheduler.sv
// Sequencer for the convolutional encoder datapath: one full frame pass per
// output filter (flush, stream input addresses, map output strobes to padded
// addresses), then advance the filter until all filters are done.
// CONV_ENCODER_SCHED_PAD_CLEAR_EN adds a per-filter border zero-clear sweep.
import conv_encoder_pkg::*;

module conv_encoder_scheduler #(
  parameter int ROWS        = conv_encoder_pkg::ROWS,
  parameter int COLS        = conv_encoder_pkg::COLS,
  parameter int PAD         = conv_encoder_pkg::PAD,
  parameter int NUM_FILTERS = conv_encoder_pkg::NUM_FILTERS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          dp_flush,
  output logic          dp_run,
  output logic [AW-1:0] in_addr,
  input  logic          dp_valid,
  output logic [AW-1:0] out_addr,
  output logic          out_we,
  output logic          out_zero,
  output logic [3:0]    filter_sel,
  output logic          err
);
  localparam logic [AW-1:0] PIX_LAST = AW'(ROWS*COLS - 1);
  localparam logic [3:0]    F_LAST   = 4'(NUM_FILTERS - 1);
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
  localparam state_t S_AFTER = S_CLEAR;
`else
  localparam state_t S_AFTER = S_NEXT;
`endif

  state_t        state, nxt;
  logic [AW-1:0] count;
  logic          abort_act, start_acc, streaming, wr, pass_end, load_first;

  assign abort_act = abort && (state != S_IDLE);
  assign start_acc = start && (state == S_IDLE || state == S_DONE) && !abort_act;
  assign streaming = (state == S_STREAM) || (state == S_DRAIN);
  assign wr        = dp_valid && streaming && !abort_act;
  assign pass_end  = wr && (count == PIX_LAST);

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign dp_run   = (state == S_STREAM);
  assign dp_flush = (state == S_FLUSH) || abort_act;

`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
  logic clr_act, border, at_end;
  assign clr_act  = (state == S_CLEAR) && !abort_act;
  assign out_we   = wr || (clr_act && border);
  assign out_zero = clr_act;
`else
  assign out_we   = wr;
  assign out_zero = 1'b0;
`endif

  conv_encoder_out_addr_gen #(
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
    .ROWS(ROWS),
`endif
    .COLS(COLS),
    .PAD (PAD)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load_first (load_first),
    .step_active(wr),
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
    .load_zero  (pass_end),
    .step_linear(clr_act),
    .border     (border),
    .at_end     (at_end),
`endif
    .addr       (out_addr)
  );

  // Next-state decode; load_first marks every entry into FLUSH (and CLEAR exit).
  always_comb begin
    nxt        = state;
    load_first = 1'b0;
    if (abort_act) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin nxt = S_FLUSH; load_first = 1'b1; end
        S_FLUSH:        nxt = S_STREAM;
        S_STREAM:       if (pass_end) nxt = S_AFTER;
                        else if (in_addr == PIX_LAST) nxt = S_DRAIN;
        S_DRAIN:        if (pass_end) nxt = S_AFTER;
`ifdef CONV_ENCODER_SCHED_PAD_CLEAR_EN
        S_CLEAR:        if (at_end) begin nxt = S_NEXT; load_first = 1'b1; end
`endif
        S_NEXT:         if (filter_sel == F_LAST) nxt = S_DONE;
                        else begin nxt = S_FLUSH; load_first = 1'b1; end
        default:        nxt = S_IDLE;
      endcase
    end
  end

  // State, input address, pixel count, filter select and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_addr    <= '0;
      count      <= '0;
      filter_sel <= '0;
      err        <= 1'b0;
    end else begin
      state <= nxt;
      if (load_first) in_addr <= '0;
      else if (state == S_STREAM && !abort_act && in_addr != PIX_LAST) in_addr <= in_addr + 1'b1;
      if (load_first) count <= '0;
      else if (wr) count <= count + 1'b1;
      if (start_acc) filter_sel <= '0;
      else if (state == S_NEXT && !abort_act && filter_sel != F_LAST) filter_sel <= filter_sel + 1'b1;
      if (start_acc) err <= 1'b0;
      else if (dp_valid && !streaming) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_encoder_scheduler.sv
// Directed bench: full-size DUT for address mapping, random strobes, abort and
// err; small-geometry DUT (4x5, pad 3) for the complete 16-filter run.
module tb_conv_encoder_scheduler;
  localparam int ROWS = 180, COLS = 64, PAD = 3, W = 70;
  localparam int SR = 4, SC = 5, SP = 3, SW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic start = 0, abort = 0, dp_valid = 0;
  logic busy, done, dp_flush, dp_run, out_we, out_zero, err;
  logic [13:0] in_addr, out_addr;
  logic [3:0]  filter_sel;

  logic start_s = 0, abort_s = 0, dp_valid_s = 0;
  logic busy_s, done_s, dp_flush_s, dp_run_s, out_we_s, out_zero_s, err_s;
  logic [13:0] in_addr_s, out_addr_s;
  logic [3:0]  filter_sel_s;

  conv_encoder_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .dp_flush(dp_flush), .dp_run(dp_run), .in_addr(in_addr), .dp_valid(dp_valid),
    .out_addr(out_addr), .out_we(out_we), .out_zero(out_zero),
    .filter_sel(filter_sel), .err(err));

  conv_encoder_scheduler #(.ROWS(SR), .COLS(SC), .PAD(SP), .NUM_FILTERS(16)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .busy(busy_s), .done(done_s),
    .dp_flush(dp_flush_s), .dp_run(dp_run_s), .in_addr(in_addr_s), .dp_valid(dp_valid_s),
    .out_addr(out_addr_s), .out_we(out_we_s), .out_zero(out_zero_s),
    .filter_sel(filter_sel_s), .err(err_s));

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Datapath model for the full-size DUT: ~5-cycle latency, pending-pixel
  // credit so that sparse (random) strobes still deliver every pixel.
  logic [4:0] pipe = '0;
  int  pend = 0;
  bit  rnd = 0, inj = 0;
  always @(posedge clk) begin
    int pn;
    if (dp_flush) begin
      pipe     <= '0;
      pend      = 0;
      dp_valid <= inj;
    end else begin
      pn = pend + int'(pipe[4]) - int'(dp_valid);
      if (pn < 0) pn = 0;
      pend      = pn;
      pipe     <= {pipe[3:0], dp_run};
      dp_valid <= inj || (pn > 0 && (!rnd || $urandom_range(0, 1) == 1));
    end
  end

  // Dense datapath model for the small DUT.
  logic [4:0] pipe_s = '0;
  always @(posedge clk) begin
    if (dp_flush_s) begin pipe_s <= '0; dp_valid_s <= 1'b0; end
    else begin pipe_s <= {pipe_s[3:0], dp_run_s}; dp_valid_s <= pipe_s[4]; end
  end

  // Write monitors; expected address of pixel k = (PAD+k/COLS)*W + PAD + k%COLS.
  int wcnt = 0, tot = 0, bad = 0, prev = 0, nxt276 = 0, first_a = 0, last_a = 0;
  int rows [0:ROWS-1];
  int wcnt_s = 0, tot_s = 0, bad_s = 0, flush_s = 0;
  always @(negedge clk) begin
    int e, r;
    if (dp_flush) begin
      wcnt = 0; bad = 0; prev = 0; nxt276 = 0; first_a = 0; last_a = 0;
      foreach (rows[i]) rows[i] = 0;
    end
    if (out_we) begin
      e = (PAD + wcnt / COLS) * W + PAD + wcnt % COLS;
      if (int'(out_addr) != e) bad++;
      if (wcnt == 0) first_a = int'(out_addr);
      last_a = int'(out_addr);
      if (prev == 276) nxt276 = int'(out_addr);
      prev = int'(out_addr);
      r = int'(out_addr) / W - PAD;
      if (r >= 0 && r < ROWS) rows[r]++;
      wcnt++; tot++;
    end
    if (dp_flush_s) begin wcnt_s = 0; flush_s++; end
    if (out_we_s) begin
      if (int'(out_addr_s) != (SP + wcnt_s / SC) * SW + SP + wcnt_s % SC) bad_s++;
      wcnt_s++; tot_s++;
    end
  end

  task automatic check_pass(input string tag);
    int rb;
    rb = 0;
    for (int r = 0; r < ROWS; r++) if (rows[r] != COLS) rb++;
    chk({tag, "_writes"}, wcnt, ROWS*COLS);
    chk({tag, "_first"}, first_a, 213);
    chk({tag, "_last"}, last_a, 12806);
    chk({tag, "_addr_bad"}, bad, 0);
    chk({tag, "_after276"}, nxt276, 283);
    chk({tag, "_rows_not64"}, rb, 0);
    chk({tag, "_in_sat"}, in_addr, 11519);
    chk({tag, "_drain_norun"}, dp_run, 0);
  endtask

  initial begin
    int w0, f0, t0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_flush", dp_flush, 0);  chk("rst_run", dp_run, 0);
    chk("rst_in_addr", in_addr, 0); chk("rst_out_addr", out_addr, 213);
    chk("rst_we", out_we, 0);       chk("rst_zero", out_zero, 0);
    chk("rst_filter", filter_sel, 0); chk("rst_err", err, 0);
    chk("rst_s_out_addr", out_addr_s, 36);
    rst = 0;
    cyc(1);
    chk("idle_busy", busy, 0);

    // start -> FLUSH next cycle -> STREAM with in_addr 0
    start = 1; cyc(1); start = 0;
    chk("flush_pulse", dp_flush, 1); chk("flush_busy", busy, 1);
    chk("flush_filter", filter_sel, 0); chk("flush_out_addr", out_addr, 213);
    chk("flush_in_addr", in_addr, 0);
    cyc(1);
    chk("stream_run", dp_run, 1); chk("stream_flush_off", dp_flush, 0);
    chk("stream_in0", in_addr, 0);
    start = 1; cyc(1); start = 0;
    chk("busy_start_in1", in_addr, 1);
    cyc(1);
    chk("busy_start_noflush", dp_flush, 0); chk("busy_start_in2", in_addr, 2);

    // pass 0, dense strobes
    for (int i = 0; i < 20000 && wcnt < ROWS*COLS; i++) cyc(1);
    check_pass("p0");
    cyc(1); chk("turn_next_noflush", dp_flush, 0);
    cyc(1); chk("turn_flush", dp_flush, 1); chk("turn_filter1", filter_sel, 1);

    // pass 1, random 50% strobes
    rnd = 1;
    for (int i = 0; i < 40000 && wcnt < ROWS*COLS; i++) cyc(1);
    check_pass("p1");
    cyc(2); chk("p2_flush", dp_flush, 1); chk("p2_filter", filter_sel, 2);
    rnd = 0;

    // abort during filter 2 at in_addr 4000
    for (int i = 0; i < 6000 && in_addr != 3999; i++) cyc(1);
    @(posedge clk); #1;
    abort = 1; w0 = tot;
    @(negedge clk); #1;
    chk("abort_in_addr", in_addr, 4000);
    chk("abort_flush", dp_flush, 1); chk("abort_no_we", out_we, 0);
    cyc(1); abort = 0;
    chk("abort_idle", busy, 0); chk("abort_one_flush", dp_flush, 0);
    chk("abort_filter_held", filter_sel, 2); chk("abort_no_writes", tot, w0);

    // dp_valid in IDLE: no write, err set, cleared by start
    inj = 1; cyc(1); inj = 0;
    chk("idle_vld_no_we", out_we, 0);
    cyc(1);
    chk("idle_vld_err", err, 1); chk("idle_vld_no_writes", tot, w0);
    start = 1; cyc(1); start = 0;
    chk("restart_err_clr", err, 0); chk("restart_filter0", filter_sel, 0);
    chk("restart_flush", dp_flush, 1);
    abort = 1; cyc(1); abort = 0;
    chk("abort_flush_idle", busy, 0);

    // small geometry: complete 16-filter run
    start_s = 1; cyc(1); start_s = 0;
    chk("s_flush", dp_flush_s, 1); chk("s_out_addr", out_addr_s, 36);
    for (int i = 0; i < 2000 && !done_s; i++) cyc(1);
    chk("s_done", done_s, 1); chk("s_busy", busy_s, 0);
    chk("s_filter15", filter_sel_s, 15); chk("s_total_writes", tot_s, 320);
    chk("s_flushes", flush_s, 16); chk("s_addr_bad", bad_s, 0);
    cyc(5); chk("s_done_held", done_s, 1);
    start_s = 1; cyc(1); start_s = 0;
    chk("s_restart_done", done_s, 0); chk("s_restart_busy", busy_s, 1);
    chk("s_restart_filter", filter_sel_s, 0);

    // small geometry: abort during filter 7
    for (int i = 0; i < 1000 && !(filter_sel_s == 7 && in_addr_s == 9); i++) cyc(1);
    @(posedge clk); #1;
    abort_s = 1; f0 = flush_s; t0 = tot_s;
    @(negedge clk); #1;
    chk("s_abort_flush", dp_flush_s, 1); chk("s_abort_no_we", out_we_s, 0);
    cyc(1); abort_s = 0;
    chk("s_abort_idle", busy_s, 0); chk("s_abort_not_done", done_s, 0);
    chk("s_abort_filter7", filter_sel_s, 7); chk("s_abort_one_flush", dp_flush_s, 0);
    chk("s_abort_no_writes", tot_s, t0); chk("s_abort_flush_cnt", flush_s, f0 + 1);
    start_s = 1; cyc(1); start_s = 0;
    chk("s_abort_restart_filter", filter_sel_s, 0); chk("s_abort_restart_flush", dp_flush_s, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
